// File: rtl/wb_load_queue_if.sv
// wb_load_queue_if: groups the MEM-side enqueue, memory-response, flush and
// register-file writeback signals of the in-order writeback load queue.
// The master modport is the pipeline/memory side; the slave modport is the queue.
interface wb_load_queue_if #(
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [REG_AW-1:0] in_regf;
  logic [31:0]       in_data;
  logic [31:0]       in_pc;
  logic [1:0]        in_ofs;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              flush;
  logic              wb_we;
  logic [REG_AW-1:0] wb_regf;
  logic [31:0]       wb_data;
  logic              busy;
  logic              err_resp;

  modport master (
    output in_valid, in_kind, in_regf, in_data, in_pc, in_ofs,
    output resp_valid, resp_data, flush,
    input  in_ready, wb_we, wb_regf, wb_data, busy, err_resp
  );

  modport slave (
    input  in_valid, in_kind, in_regf, in_data, in_pc, in_ofs,
    input  resp_valid, resp_data, flush,
    output in_ready, wb_we, wb_regf, wb_data, busy, err_resp
  );
endinterface

// File: rtl/wb_load_queue.sv
// wb_load_queue: in-order writeback unit. Retiring MEM-stage instructions are
// held in a DEPTH-entry FIFO; in-order memory responses fill the oldest load
// still waiting for data; the head retires to the register-file write port
// (registered, one per cycle) once complete. Load data is byte-aligned and
// sign/zero extended at retire time.
// Optional feature macro: WB_UNALIGNED_EN enables LWL/LWR merging into the old
// rt value; without it those kinds retire as NONE and expect no response.
module wb_load_queue #(
  parameter int          DEPTH    = 4,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] LINK_OFS = 32'd8
) (
  input  logic           clk,
  input  logic           resetn,
  wb_load_queue_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Drop counter is wide enough to absorb many back-to-back flushes.
  localparam int DROP_W = 16;

  typedef enum logic [3:0] {
    K_NONE = 4'd0,
    K_ALU  = 4'd1,
    K_LINK = 4'd2,
    K_LB   = 4'd3,
    K_LBU  = 4'd4,
    K_LH   = 4'd5,
    K_LHU  = 4'd6,
    K_LW   = 4'd7,
    K_LWL  = 4'd8,
    K_LWR  = 4'd9
  } kind_e;

  // Queue payload storage
  kind_e             kind_q [DEPTH];
  logic [REG_AW-1:0] regf_q [DEPTH];
  logic [31:0]       data_q [DEPTH];  // ALU result, link value or old rt
  logic [31:0]       mem_q  [DEPTH];  // captured memory word for loads
  logic [1:0]        ofs_q  [DEPTH];
  logic              load_q [DEPTH];
  logic              done_q [DEPTH];

  // Control state
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              wb_we_q;
  logic [REG_AW-1:0] wb_regf_q;
  logic [31:0]       wb_data_q;
  logic              err_q;

  // Combinational helpers
  kind_e             in_kind_n;
  logic              in_is_load;
  logic [31:0]       in_payload;
  logic              fill_hit;
  logic [PTR_W-1:0]  fill_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic [CNT_W-1:0]  pend_cnt;
  logic              head_done, head_we;
  logic              push, retire;
  logic              resp_drop, resp_fill, resp_err;
  logic [31:0]       head_result;

  // Byte-lane alignment, extension and (optionally) unaligned merge
  function automatic logic [31:0] load_result(input kind_e k, input logic [31:0] mem,
                                              input logic [1:0] ofs, input logic [31:0] rt);
    logic [31:0] m;
    m = mem >> {ofs, 3'b000};
    case (k)
      K_LB:  load_result = {{24{m[7]}}, m[7:0]};
      K_LBU: load_result = {24'h0, m[7:0]};
      K_LH:  load_result = {{16{m[15]}}, m[15:0]};
      K_LHU: load_result = {16'h0, m[15:0]};
      K_LW:  load_result = m;
`ifdef WB_UNALIGNED_EN
      K_LWL: load_result = (mem << {2'd3 - ofs, 3'b000})
                         | (rt & ((32'h1 << {2'd3 - ofs, 3'b000}) - 32'h1));
      K_LWR: load_result = (mem >> {ofs, 3'b000})
                         | (rt & ~(32'hFFFF_FFFF >> {ofs, 3'b000}));
`endif
      default: load_result = rt;
    endcase
  endfunction

  // Normalise the incoming kind: reserved (and disabled unaligned) kinds become NONE
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    in_kind_n  = K_NONE;
    in_is_load = 1'b0;
    in_payload = bus.in_data;
    case (bus.in_kind)
      4'd1: in_kind_n = K_ALU;
      4'd2: begin
        in_kind_n  = K_LINK;
        in_payload = bus.in_pc + LINK_OFS;
      end
      4'd3: begin in_kind_n = K_LB;  in_is_load = 1'b1; end
      4'd4: begin in_kind_n = K_LBU; in_is_load = 1'b1; end
      4'd5: begin in_kind_n = K_LH;  in_is_load = 1'b1; end
      4'd6: begin in_kind_n = K_LHU; in_is_load = 1'b1; end
      4'd7: begin in_kind_n = K_LW;  in_is_load = 1'b1; end
`ifdef WB_UNALIGNED_EN
      4'd8: begin in_kind_n = K_LWL; in_is_load = 1'b1; end
      4'd9: begin in_kind_n = K_LWR; in_is_load = 1'b1; end
`endif
      default: in_kind_n = K_NONE;
    endcase
  end

  // Find the oldest load lacking data and count all such loads (for flush)
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    scan_idx = '0;
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && load_q[scan_idx] && !done_q[scan_idx]) begin
        pend_cnt = pend_cnt + CNT_W'(1);
        if (!fill_hit) begin
          fill_hit = 1'b1;
          fill_idx = scan_idx;
        end
      end
    end
  end

  // Handshake, retire and response-routing decisions
  always_comb begin
    head_done    = (count_q != '0) && done_q[head_q];
    head_we      = (kind_q[head_q] != K_NONE) && (regf_q[head_q] != '0);
    head_result  = load_result(kind_q[head_q], mem_q[head_q], ofs_q[head_q], data_q[head_q]);
    bus.in_ready = !bus.flush && ((count_q != CNT_W'(DEPTH)) || head_done);
    push         = bus.in_valid && bus.in_ready;
    retire       = head_done && !bus.flush;
    resp_drop    = bus.resp_valid && (drop_cnt_q != '0);
    resp_fill    = bus.resp_valid && (drop_cnt_q == '0) && fill_hit;
    resp_err     = bus.resp_valid && (drop_cnt_q == '0) && !fill_hit;
  end

  // Next occupancy and drop count; a flush-cycle response is applied before the flush
  always_comb begin
    count_d    = count_q + CNT_W'(push) - CNT_W'(retire);
    drop_cnt_d = drop_cnt_q;
    if (resp_drop) drop_cnt_d = drop_cnt_d - DROP_W'(1);
    if (bus.flush) begin
      count_d    = '0;
      drop_cnt_d = drop_cnt_d + DROP_W'(pend_cnt) - DROP_W'(resp_fill);
    end
  end

  // Control registers: pointers, counters, writeback port, sticky error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      wb_we_q    <= 1'b0;
      wb_regf_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      if (bus.flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push)   tail_q <= tail_q + PTR_W'(1);
        if (retire) head_q <= head_q + PTR_W'(1);
      end
      wb_we_q <= retire && head_we;
      if (retire && head_we) begin
        wb_regf_q <= regf_q[head_q];
        wb_data_q <= head_result;
      end
      if (resp_err) err_q <= 1'b1;
    end
  end

  // Payload storage: written on enqueue and on response capture
  // NOTE: payload is not reset; occupancy (count_q) alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      kind_q[tail_q] <= in_kind_n;
      regf_q[tail_q] <= bus.in_regf;
      data_q[tail_q] <= in_payload;
      ofs_q[tail_q]  <= bus.in_ofs;
      load_q[tail_q] <= in_is_load;
      done_q[tail_q] <= !in_is_load;
    end
    if (resp_fill) begin
      mem_q[fill_idx]  <= bus.resp_data;
      done_q[fill_idx] <= 1'b1;
    end
  end

  assign bus.wb_we    = wb_we_q;
  assign bus.wb_regf  = wb_regf_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.busy     = (count_q != '0) || (drop_cnt_q != '0);
  assign bus.err_resp = err_q;

endmodule

// File: tb/tb_wb_load_queue.sv
// tb_wb_load_queue: scenario tasks drive the queue; expected register writes
// are pushed to a scoreboard at enqueue and popped by a writeback monitor.
// Define WB_UNALIGNED_EN to exercise LWL/LWR merging.
module tb_wb_load_queue;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [REG_AW-1:0] regf;
    logic [31:0]       data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_exp;

  wb_load_queue_if #(.REG_AW(REG_AW)) bus ();

  wb_load_queue #(.DEPTH(4), .REG_AW(REG_AW), .LINK_OFS(32'd8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Writeback monitor: every write must match the next scoreboard entry
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.wb_we === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got regf=%0d data=%h, required no write", bus.wb_regf, bus.wb_data);
      end else begin
        mon_exp = sb.pop_front();
        if (bus.wb_regf !== mon_exp.regf || bus.wb_data !== mon_exp.data) begin
          bad++;
          $display("FAIL wb_write: got regf=%0d data=%h, required regf=%0d data=%h",
                   bus.wb_regf, bus.wb_data, mon_exp.regf, mon_exp.data);
        end
      end
    end
  end

  // Independent load model built from explicit byte lanes
  function automatic logic [31:0] exp_load(input int kind, input logic [31:0] w, input int ofs);
    logic [7:0] b [4];
    logic [7:0] lo, hi;
    b[0] = w[7:0];  b[1] = w[15:8];  b[2] = w[23:16]; b[3] = w[31:24];
    lo = b[ofs];
    hi = (ofs < 3) ? b[ofs + 1] : 8'h00;
    case (kind)
      3: exp_load = {{24{lo[7]}}, lo};
      4: exp_load = {24'h0, lo};
      5: exp_load = {{16{hi[7]}}, hi, lo};
      6: exp_load = {16'h0, hi, lo};
      default: begin
        exp_load = 32'h0;
        for (int k = 0; k < 4; k++)
          if (ofs + k < 4) exp_load[8*k +: 8] = b[ofs + k];
      end
    endcase
  endfunction

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_kind    = 4'd0;
    bus.in_regf    = '0;
    bus.in_data    = 32'h0;
    bus.in_pc      = 32'h0;
    bus.in_ofs     = 2'd0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = 32'h0;
    bus.flush      = 1'b0;
  endtask

  // Present one instruction; returns on the negedge after it is accepted
  task automatic enq(input logic [3:0] kind, input logic [REG_AW-1:0] regf,
                     input logic [31:0] data, input logic [31:0] pc, input logic [1:0] ofs,
                     input logic exp_we, input logic [31:0] exp_data);
    bus.in_valid = 1'b1;
    bus.in_kind  = kind;
    bus.in_regf  = regf;
    bus.in_data  = data;
    bus.in_pc    = pc;
    bus.in_ofs   = ofs;
    if (exp_we) sb.push_back(wr_t'{regf: regf, data: exp_data});
    for (int n = 0; n < 50; n++) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL enq_timeout: in_ready stayed %b, required 1 within 50 cycles", bus.in_ready);
    bus.in_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] d);
    bus.resp_valid = 1'b1;
    bus.resp_data  = d;
    @(posedge clk);
    @(negedge clk);
    bus.resp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50; n++) begin
      if (bus.busy === 1'b0) break;
      @(negedge clk);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL drain: busy=%b, required 0 within 50 cycles", bus.busy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL rst_wb_we: got %b want 0", bus.wb_we); end
    total++; if (bus.wb_regf !== '0) begin bad++; $display("FAIL rst_wb_regf: got %0d want 0", bus.wb_regf); end
    total++; if (bus.wb_data !== 32'h0) begin bad++; $display("FAIL rst_wb_data: got %h want 0", bus.wb_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.err_resp !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err_resp); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_latency();
    enq(4'd1, 5'd3, 32'h0000_1234, 32'h0, 2'd0, 1'b1, 32'h0000_1234);
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL alu_early: wb_we=%b want 0", bus.wb_we); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL alu_busy: got %b want 1", bus.busy); end
    @(negedge clk);
    total++; if (bus.wb_we !== 1'b1) begin bad++; $display("FAIL alu_latency: wb_we=%b want 1", bus.wb_we); end
    wait_idle();
  endtask

  task automatic test_link_r0_reserved();
    enq(4'd2, 5'd31, 32'h0, 32'hBFC0_0010, 2'd0, 1'b1, 32'hBFC0_0018);
    enq(4'd1, 5'd0, 32'hDEAD_BEEF, 32'h0, 2'd0, 1'b0, 32'h0);
    enq(4'd12, 5'd9, 32'h1357_9BDF, 32'h0, 2'd0, 1'b0, 32'h0);
    enq(4'd0, 5'd10, 32'h2468_ACE0, 32'h0, 2'd0, 1'b0, 32'h0);
    wait_idle();
  endtask

  task automatic test_load_ext();
    logic [31:0] w;
    int kind, ofs;
    enq(4'd3, 5'd4, 32'h0, 32'h0, 2'd2, 1'b1, 32'hFFFF_FF80);
    enq(4'd6, 5'd7, 32'h0, 32'h0, 2'd2, 1'b1, 32'h0000_0080);
    @(negedge clk);
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL load_wait: wb_we=%b want 0", bus.wb_we); end
    resp(32'h0080_6A00);
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL load_bypass: wb_we=%b want 0", bus.wb_we); end
    @(negedge clk);
    total++; if (bus.wb_we !== 1'b1) begin bad++; $display("FAIL load_latency: wb_we=%b want 1", bus.wb_we); end
    resp(32'h0080_6A00);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      w    = $urandom;
      kind = 3 + int'($urandom_range(0, 4));
      ofs  = int'($urandom_range(0, 3));
      enq(4'(kind), 5'(1 + i), 32'h0, 32'h0, 2'(ofs), 1'b1, exp_load(kind, w, ofs));
      resp(w);
    end
    wait_idle();
  endtask

  task automatic test_order_full();
    enq(4'd7, 5'd5, 32'h0, 32'h0, 2'd0, 1'b1, 32'h5555_AAAA);
    enq(4'd1, 5'd6, 32'h0000_0066, 32'h0, 2'd0, 1'b1, 32'h0000_0066);
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL order_r6_first: wb_we=%b want 0", bus.wb_we); end
    enq(4'd1, 5'd8, 32'h0000_0088, 32'h0, 2'd0, 1'b1, 32'h0000_0088);
    enq(4'd1, 5'd9, 32'h0000_0099, 32'h0, 2'd0, 1'b1, 32'h0000_0099);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_stall: in_ready=%b want 0", bus.in_ready); end
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL order_hold: wb_we=%b want 0", bus.wb_we); end
    fork
      enq(4'd1, 5'd10, 32'h0000_00AA, 32'h0, 2'd0, 1'b1, 32'h0000_00AA);
      resp(32'h5555_AAAA);
    join
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.wb_we !== 1'b1) begin bad++; $display("FAIL order_consec%0d: wb_we=%b want 1", i, bus.wb_we); end
      @(negedge clk);
    end
    wait_idle();
  endtask

  task automatic test_flush();
    enq(4'd3, 5'd11, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    enq(4'd7, 5'd12, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    bus.flush = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: in_ready=%b want 0", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL flush_we: wb_we=%b want 0", bus.wb_we); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_busy: got %b want 1", bus.busy); end
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL drop_ready: in_ready=%b want 1", bus.in_ready); end
    enq(4'd7, 5'd13, 32'h0, 32'h0, 2'd0, 1'b1, 32'hCAFE_F00D);
    resp(32'h1111_1111);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL drop1_busy: got %b want 1", bus.busy); end
    resp(32'h2222_2222);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL drop2_busy: got %b want 1", bus.busy); end
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL drop_we: wb_we=%b want 0", bus.wb_we); end
    resp(32'hCAFE_F00D);
    @(negedge clk);
    total++; if (bus.err_resp !== 1'b0) begin bad++; $display("FAIL flush_err: got %b want 0", bus.err_resp); end
    wait_idle();
  endtask

  task automatic test_unaligned();
`ifdef WB_UNALIGNED_EN
    enq(4'd8, 5'd14, 32'h1122_3344, 32'h0, 2'd1, 1'b1, 32'hCCDD_3344);
    resp(32'hAABB_CCDD);
    enq(4'd9, 5'd15, 32'h1122_3344, 32'h0, 2'd2, 1'b1, 32'h1122_AABB);
    resp(32'hAABB_CCDD);
`else
    enq(4'd8, 5'd14, 32'h1122_3344, 32'h0, 2'd1, 1'b0, 32'h0);
    enq(4'd9, 5'd15, 32'h1122_3344, 32'h0, 2'd2, 1'b0, 32'h0);
`endif
    wait_idle();
    total++; if (bus.err_resp !== 1'b0) begin bad++; $display("FAIL unal_err: got %b want 0", bus.err_resp); end
  endtask

  task automatic test_reset_mid();
    enq(4'd7, 5'd16, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    enq(4'd1, 5'd17, 32'h0000_0017, 32'h0, 2'd0, 1'b0, 32'h0);
    resetn = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL midrst_we: got %b want 0", bus.wb_we); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_err_resp();
    resp(32'h0BAD_0BAD);
    total++; if (bus.err_resp !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", bus.err_resp); end
    enq(4'd1, 5'd18, 32'h0000_0018, 32'h0, 2'd0, 1'b1, 32'h0000_0018);
    repeat (3) @(negedge clk);
    total++; if (bus.err_resp !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.err_resp); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_alu_latency();
    test_link_r0_reserved();
    test_load_ext();
    test_order_full();
    test_flush();
    test_unaligned();
    test_reset_mid();
    test_err_resp();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d writes outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
